// File: rtl/fp16_pack_out.sv
// Final MAC stage: packs {sign, norm_sum, exp_final} into binary16 and queues the
// result in a small valid/ready FIFO, counting overflow and underflow events.
module fp16_pack_out #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [10:0]      norm_sum,
  input  logic [6:0]       exp_final,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp16,
  output logic [1:0]       out_flags,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic signed [7:0] exp_b;
  logic [7:0]        sh;
  logic [9:0]        sub_mant;
  logic [15:0]       pk_fp16;
  logic              pk_ovf;
  logic              pk_unf;

  // Biased exponent in 8-bit signed arithmetic so it never wraps.
  assign exp_b    = $signed({exp_final[6], exp_final}) + 8'sd15;
  assign sh       = 8'd1 - exp_b;
  assign sub_mant = 10'(norm_sum >> sh);

  always_comb begin
    pk_fp16 = '0;
    pk_ovf  = 1'b0;
    pk_unf  = 1'b0;
    if (norm_sum == '0) begin
      pk_fp16 = '0;
    end else if (exp_b >= 8'sd31) begin
      pk_fp16 = {sign, 5'h1F, 10'h000};
      pk_ovf  = 1'b1;
    end else if (exp_b >= 8'sd1) begin
      pk_fp16 = {sign, exp_b[4:0], norm_sum[9:0]};
    end else if (sh <= 8'd10) begin
      pk_fp16 = {sign, 5'h00, sub_mant};
    end else begin
      pk_fp16 = {sign, 15'h0000};
      pk_unf  = 1'b1;
    end
  end

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  logic [17:0] mem [FIFO_DEPTH];
  logic [17:0] head;

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr_q[AW-1:0]];
  // Gate the head so an empty FIFO always presents zeros.
  assign out_fp16  = out_valid ? head[15:0]  : '0;
  assign out_flags = out_valid ? head[17:16] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {pk_ovf, pk_unf, pk_fp16};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  logic [CNT_W-1:0] ovf_cnt_q, unf_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (cnt_clr) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if (push && pk_ovf && (ovf_cnt_q != '1)) ovf_cnt_q <= ovf_cnt_q + 1'b1;
      if (push && pk_unf && (unf_cnt_q != '1)) unf_cnt_q <= unf_cnt_q + 1'b1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign unf_cnt = unf_cnt_q;

endmodule

// File: tb/tb_fp16_pack_out.sv
// Bench for fp16_pack_out: directed steps plus random traffic against a queue-based
// reference model of the packer, FIFO and event counters.
module tb_fp16_pack_out;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sign, out_valid, out_ready, cnt_clr;
  logic [10:0] norm_sum;
  logic [6:0]  exp_final;
  logic [15:0] out_fp16;
  logic [1:0]  out_flags;
  logic [7:0]  ovf_cnt, unf_cnt;

  int total = 0;
  int bad   = 0;
  logic [17:0] q[$];
  int om = 0;
  int um = 0;

  fp16_pack_out #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
    .norm_sum(norm_sum), .exp_final(exp_final), .out_valid(out_valid),
    .out_ready(out_ready), .out_fp16(out_fp16), .out_flags(out_flags),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  always #5 clk = ~clk;

  // Value = (-1)^s * n/1024 * 2^e, returned as {ovf, unf, fp16}.
  function automatic int model(bit s, int n, int e);
    int ee, sh;
    ee = e + 15;
    if (n == 0) return 0;
    if (ee >= 31) return (2 << 16) | (int'(s) << 15) | (31 << 10);
    if (ee >= 1) return (int'(s) << 15) | (ee << 10) | (n % 1024);
    sh = 1 - ee;
    if (sh <= 10) return (int'(s) << 15) | ((n >> sh) % 1024);
    return (1 << 16) | (int'(s) << 15);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(bit v, bit s, logic [10:0] n, logic [6:0] e);
    in_valid  = v;
    sign      = s;
    norm_sum  = n;
    exp_final = e;
  endtask

  // One clock with model update and full output check.
  task automatic tick();
    bit acc, pp;
    logic [17:0] w;
    acc = in_valid && (q.size() < DEPTH);
    pp  = out_ready && (q.size() > 0);
    w   = 18'(model(sign, int'(norm_sum), int'($signed(exp_final))));
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(w);
    if (cnt_clr) begin
      om = 0;
      um = 0;
    end else if (acc) begin
      if (w[17] && om < 255) om++;
      if (w[16] && um < 255) um++;
    end
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(om));
    chk("unf_cnt", 32'(unf_cnt), 32'(um));
    if (q.size() > 0) begin
      chk("out_fp16", 32'(out_fp16), 32'(q[0][15:0]));
      chk("out_flags", 32'(out_flags), 32'(q[0][17:16]));
    end
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_fp16"}, 32'(out_fp16), 32'd0);
    chk({tag, "_out_flags"}, 32'(out_flags), 32'd0);
    chk({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'd0);
    chk({tag, "_unf_cnt"}, 32'(unf_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    drive(0, 0, 11'h0, 7'h0);
    #12;
    reset_checks("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic packing with a free-running consumer.
    drive(1, 0, 11'h400, 7'd0);
    tick();
    chk("t1_one", 32'(out_fp16), 32'h3C00);
    chk("t1_flags", 32'(out_flags), 32'h0);
    drive(1, 1, 11'h600, 7'd1);
    tick();
    chk("t2_neg", 32'(out_fp16), 32'hC200);
    drive(1, 0, 11'h400, 7'd16);
    tick();
    chk("t2_inf", 32'(out_fp16), 32'h7C00);
    chk("t2_ovf", 32'(out_flags), 32'h2);
    drive(1, 0, 11'h400, 7'(-15));
    tick();
    chk("t3_sub", 32'(out_fp16), 32'h0200);
    drive(1, 0, 11'h400, 7'(-30));
    tick();
    chk("t3_ftz", 32'(out_fp16), 32'h0000);
    chk("t3_unf", 32'(out_flags), 32'h1);
    drive(1, 1, 11'h000, 7'd5);
    tick();
    chk("t3_zero", 32'(out_fp16), 32'h0000);
    drive(0, 0, 11'h0, 7'h0);
    tick();

    // Backpressure: fill, hold third input, then drain in order.
    out_ready = 1'b0;
    drive(1, 0, 11'h401, 7'd0);
    tick();
    drive(1, 0, 11'h402, 7'd0);
    tick();
    drive(1, 0, 11'h403, 7'd0);
    tick();
    chk("t4_full", 32'(in_ready), 32'd0);
    tick();
    chk("t4_hold", 32'(out_fp16), 32'h3C01);
    out_ready = 1'b1;
    repeat (3) tick();
    drive(0, 0, 11'h0, 7'h0);
    repeat (2) tick();

    // Counter saturation and clear priority.
    drive(1, 0, 11'h7FF, 7'd40);
    repeat (256) tick();
    chk("t5_sat", 32'(ovf_cnt), 32'd255);
    cnt_clr = 1'b1;
    tick();
    chk("t5_clr", 32'(ovf_cnt), 32'd0);
    cnt_clr = 1'b0;
    drive(0, 0, 11'h0, 7'h0);
    tick();

    // Asynchronous reset with a full FIFO.
    out_ready = 1'b0;
    drive(1, 0, 11'h400, 7'd50);
    repeat (2) tick();
    drive(0, 0, 11'h0, 7'h0);
    rst = 1'b0;
    #1;
    reset_checks("midrst");
    q.delete();
    om = 0;
    um = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [10:0] n;
      case ($urandom_range(0, 7))
        0:       n = 11'h000;
        1:       n = 11'($urandom_range(1, 2047));
        default: n = {1'b1, 10'($urandom_range(0, 1023))};
      endcase
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), n,
            7'($urandom_range(0, 127)));
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
